// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem read, registered output with a one-entry skid.
// Optional feature macro IF_SQUASH_CNT_EN adds the squash_cnt output counting redirect-dropped responses.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic        ins_valid
`ifdef IF_SQUASH_CNT_EN
  ,
  output logic [15:0] squash_cnt
`endif
);

  // Handshake: ins/ins_pc are offered while ins_valid=1; decode takes the word on an
  // edge where stall=0 (stall acts as !ready), otherwise the word is held unchanged.

  logic [31:0] r_pc;
  logic        r_inflight;
  logic [31:0] r_inflight_pc;
  logic        r_skid_valid;
  logic [31:0] r_skid_ins;
  logic [31:0] r_skid_pc;
  logic [31:0] r_ins;
  logic [31:0] r_ins_pc;
  logic        r_ins_valid;
  logic        w_req;

  assign w_req     = rst_n & ~stall & ~redirect;
  assign imem_req  = w_req;
  assign imem_addr = r_pc;
  assign ins       = r_ins;
  assign ins_pc    = r_ins_pc;
  assign ins_valid = r_ins_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'h0;
      r_skid_valid  <= 1'b0;
      r_skid_ins    <= 32'h0;
      r_skid_pc     <= 32'h0;
      r_ins         <= 32'h0;
      r_ins_pc      <= 32'h0;
      r_ins_valid   <= 1'b0;
    end else begin
      if (redirect) begin
        r_pc <= redirect_pc;
      end else if (w_req) begin
        r_pc <= r_pc + 32'd4;
      end

      r_inflight <= w_req;
      if (w_req) begin
        r_inflight_pc <= r_pc;
      end

      // A stalled response parks in the skid; since stall also blocks new requests,
      // the skid always drains before the next response can arrive.
      if (redirect) begin
        r_skid_valid <= 1'b0;
        r_ins_valid  <= 1'b0;
      end else if (stall) begin
        if (r_inflight) begin
          r_skid_valid <= 1'b1;
          r_skid_ins   <= imem_rdata;
          r_skid_pc    <= r_inflight_pc;
        end
      end else if (r_inflight) begin
        r_ins       <= imem_rdata;
        r_ins_pc    <= r_inflight_pc;
        r_ins_valid <= 1'b1;
      end else if (r_skid_valid) begin
        r_ins        <= r_skid_ins;
        r_ins_pc     <= r_skid_pc;
        r_ins_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_ins_valid <= 1'b0;
      end
    end
  end

`ifdef IF_SQUASH_CNT_EN
  logic [15:0] r_squash_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_squash_cnt <= 16'h0;
    end else if (redirect && r_inflight && (r_squash_cnt != 16'hFFFF)) begin
      r_squash_cnt <= r_squash_cnt + 16'd1;
    end
  end

  assign squash_cnt = r_squash_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized stream
// compared against an address-sequence reference model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_valid;
`ifdef IF_SQUASH_CNT_EN
  logic [15:0] squash_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (mem_rdata),
    .ins        (ins),
    .ins_pc     (ins_pc),
    .ins_valid  (ins_valid)
`ifdef IF_SQUASH_CNT_EN
    ,
    .squash_cnt (squash_cnt)
`endif
  );

  // Memory: data for a requested address appears one cycle later; garbage otherwise.
  always @(posedge clk) begin
    if (imem_req) mem_rdata <= imem_addr ^ KEY;
    else          mem_rdata <= $urandom;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      step();
      if (ins_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #2;
    n_cmp++; if (ins !== 32'h0) begin n_bad++; $display("FAIL reset_ins: got %h expected 0", ins); end
    n_cmp++; if (ins_pc !== 32'h0) begin n_bad++; $display("FAIL reset_ins_pc: got %h expected 0", ins_pc); end
    n_cmp++; if (ins_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ins_valid: got %b expected 0", ins_valid); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_imem_req: got %b expected 0", imem_req); end
    n_cmp++; if (imem_addr !== RESET_PC) begin n_bad++; $display("FAIL reset_imem_addr: got %h expected %h", imem_addr, RESET_PC); end
`ifdef IF_SQUASH_CNT_EN
    n_cmp++; if (squash_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_squash_cnt: got %h expected 0", squash_cnt); end
`endif
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    do_reset();
    step();
    n_cmp++; if (ins_valid !== 1'b0) begin n_bad++; $display("FAIL seq_first_edge_valid: got %b expected 0", ins_valid); end
    for (int k = 0; k < 3; k++) begin
      a = RESET_PC + 32'(4 * k);
      step();
      n_cmp++; if (ins_valid !== 1'b1) begin n_bad++; $display("FAIL seq_valid[%0d]: got %b expected 1", k, ins_valid); end
      n_cmp++; if (ins_pc !== a) begin n_bad++; $display("FAIL seq_ins_pc[%0d]: got %h expected %h", k, ins_pc, a); end
      n_cmp++; if (ins !== (a ^ KEY)) begin n_bad++; $display("FAIL seq_ins[%0d]: got %h expected %h", k, ins, a ^ KEY); end
    end
  endtask

  task automatic test_stall_skid();
    do_reset();
    step(); step(); step();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (ins_pc !== 32'h4) begin n_bad++; $display("FAIL stall_hold_pc[%0d]: got %h expected 4", k, ins_pc); end
      n_cmp++; if (ins !== (32'h4 ^ KEY)) begin n_bad++; $display("FAIL stall_hold_ins[%0d]: got %h expected %h", k, ins, 32'h4 ^ KEY); end
      n_cmp++; if (ins_valid !== 1'b1) begin n_bad++; $display("FAIL stall_hold_valid[%0d]: got %b expected 1", k, ins_valid); end
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL stall_req[%0d]: got %b expected 0", k, imem_req); end
    end
    stall = 1'b0;
    step();
    n_cmp++; if (ins_valid !== 1'b1 || ins_pc !== 32'h8) begin n_bad++; $display("FAIL skid_drain: got valid=%b pc=%h expected valid=1 pc=8", ins_valid, ins_pc); end
    n_cmp++; if (ins !== (32'h8 ^ KEY)) begin n_bad++; $display("FAIL skid_drain_ins: got %h expected %h", ins, 32'h8 ^ KEY); end
    step();
    n_cmp++; if (ins_valid !== 1'b1 || ins_pc !== 32'hC) begin n_bad++; $display("FAIL after_skid: got valid=%b pc=%h expected valid=1 pc=c", ins_valid, ins_pc); end
  endtask

  task automatic test_redirect_inflight();
    bit ok;
    do_reset();
    for (int k = 0; k < 5; k++) step();
    n_cmp++; if (ins_pc !== 32'hC) begin n_bad++; $display("FAIL redir_pre_pc: got %h expected c", ins_pc); end
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    n_cmp++; if (ins_valid !== 1'b0) begin n_bad++; $display("FAIL redir_valid: got %b expected 0", ins_valid); end
    n_cmp++; if (imem_addr !== 32'h100) begin n_bad++; $display("FAIL redir_addr: got %h expected 100", imem_addr); end
`ifdef IF_SQUASH_CNT_EN
    n_cmp++; if (squash_cnt !== 16'd1) begin n_bad++; $display("FAIL redir_squash_cnt: got %0d expected 1", squash_cnt); end
`endif
    wait_valid(6, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL redir_timeout: got no valid expected valid within 6 cycles"); end
    n_cmp++; if (ins_pc !== 32'h100 || ins !== (32'h100 ^ KEY)) begin n_bad++; $display("FAIL redir_target: got pc=%h ins=%h expected pc=100 ins=%h", ins_pc, ins, 32'h100 ^ KEY); end
    step();
    n_cmp++; if (ins_valid !== 1'b1 || ins_pc !== 32'h104) begin n_bad++; $display("FAIL redir_next: got valid=%b pc=%h expected valid=1 pc=104", ins_valid, ins_pc); end
  endtask

  task automatic test_redirect_skid();
    bit ok;
    do_reset();
    step(); step(); step();
    stall = 1'b1;
    step(); step();
    redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0; stall = 1'b0;
    n_cmp++; if (ins_valid !== 1'b0) begin n_bad++; $display("FAIL redir_skid_valid: got %b expected 0", ins_valid); end
`ifdef IF_SQUASH_CNT_EN
    n_cmp++; if (squash_cnt !== 16'd0) begin n_bad++; $display("FAIL redir_skid_squash_cnt: got %0d expected 0", squash_cnt); end
`endif
    wait_valid(6, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL redir_skid_timeout: got no valid expected valid within 6 cycles"); end
    n_cmp++; if (ins_pc !== 32'h200) begin n_bad++; $display("FAIL redir_skid_target: got %h expected 200", ins_pc); end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    step(); step();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    wait_valid(6, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_timeout: got no valid expected valid within 6 cycles"); end
    n_cmp++; if (ins_pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_first: got %h expected fffffffc", ins_pc); end
    step();
    n_cmp++; if (ins_valid !== 1'b1 || ins_pc !== 32'h0) begin n_bad++; $display("FAIL wrap_second: got valid=%b pc=%h expected valid=1 pc=0", ins_valid, ins_pc); end
    n_cmp++; if (ins !== (32'h0 ^ KEY)) begin n_bad++; $display("FAIL wrap_ins: got %h expected %h", ins, KEY); end
  endtask

  task automatic test_reset_midstream();
    bit ok;
    do_reset();
    for (int k = 0; k < 4; k++) step();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (ins !== 32'h0 || ins_pc !== 32'h0 || ins_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_outputs: got ins=%h pc=%h valid=%b expected all 0", ins, ins_pc, ins_valid); end
    n_cmp++; if (imem_req !== 1'b0 || imem_addr !== RESET_PC) begin n_bad++; $display("FAIL midreset_req: got req=%b addr=%h expected req=0 addr=%h", imem_req, imem_addr, RESET_PC); end
    step(); step();
    rst_n = 1'b1;
    wait_valid(6, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL midreset_timeout: got no valid expected valid within 6 cycles"); end
    n_cmp++; if (ins_pc !== RESET_PC || ins !== (RESET_PC ^ KEY)) begin n_bad++; $display("FAIL midreset_restart: got pc=%h ins=%h expected pc=%h ins=%h", ins_pc, ins, RESET_PC, RESET_PC ^ KEY); end
  endtask

  // Reference: the consumed stream is a contiguous address run restarting at each redirect
  // target; the fetch address advances by 4 on every unstalled, unredirected cycle.
  task automatic test_random();
    logic [31:0] model_pc, exp_next, rpc, pre_ins, pre_pc;
    logic        st, rd, pre_valid;
    int          delivered;
    do_reset();
    model_pc = RESET_PC; exp_next = RESET_PC; delivered = 0;
    for (int i = 0; i < 800; i++) begin
      st  = ($urandom_range(0, 99) < 30);
      rd  = ($urandom_range(0, 99) < 6);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3)))
                                        : ($urandom & 32'hFFFF_FFFC);
      stall = st; redirect = rd; redirect_pc = rpc;
      #1;
      n_cmp++; if (imem_req !== (!st && !rd)) begin n_bad++; $display("FAIL rnd_req[%0d]: got %b expected %b", i, imem_req, !st && !rd); end
      n_cmp++; if (imem_addr !== model_pc) begin n_bad++; $display("FAIL rnd_addr[%0d]: got %h expected %h", i, imem_addr, model_pc); end
      if (ins_valid && !st && !rd) begin
        n_cmp++; if (ins_pc !== exp_next || ins !== (exp_next ^ KEY)) begin n_bad++; $display("FAIL rnd_stream[%0d]: got pc=%h ins=%h expected pc=%h ins=%h", i, ins_pc, ins, exp_next, exp_next ^ KEY); end
        exp_next = exp_next + 32'd4;
        delivered++;
      end
      pre_ins = ins; pre_pc = ins_pc; pre_valid = ins_valid;
      step();
      if (rd) begin
        model_pc = rpc; exp_next = rpc;
      end else if (!st) begin
        model_pc = model_pc + 32'd4;
      end
      if (st && !rd) begin
        n_cmp++; if (ins !== pre_ins || ins_pc !== pre_pc || ins_valid !== pre_valid) begin n_bad++; $display("FAIL rnd_stall_hold[%0d]: got %h/%h/%b expected %h/%h/%b", i, ins, ins_pc, ins_valid, pre_ins, pre_pc, pre_valid); end
      end
    end
    stall = 1'b0; redirect = 1'b0;
    n_cmp++; if (delivered < 100) begin n_bad++; $display("FAIL rnd_throughput: got %0d deliveries expected at least 100", delivered); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_skid();
    test_redirect_inflight();
    test_redirect_skid();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 stall  input  1  downstream decode cannot accept; hold the output register.
REQ-005 redirect  input  1  branch/jump taken; squash in-flight work and refetch.
REQ-006 redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-007 imem_req  output  1  instruction memory read strobe (combinational).
REQ-008 imem_addr  output  32  read address, equal to the internal pc.
REQ-009 imem_rdata  input  32  read data, valid exactly one cycle after the imem_req cycle.
REQ-010 ins  output  32  registered instruction word to decode.
REQ-011 ins_pc  output  32  address of ins.
REQ-012 ins_valid  output  1  ins/ins_pc hold a real instruction.

Function
REQ-013 The block SHALL hold the state pc (32), inflight (1), inflight_pc (32), skid_valid (1), skid_ins (32), skid_pc (32), plus the output registers.
REQ-014 imem_req SHALL equal rst_n & !stall & !redirect, and imem_addr SHALL always equal pc.
REQ-015 On an edge where imem_req=1, the block SHALL set pc to pc+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0), set inflight=1, and set inflight_pc=pc; otherwise it SHALL clear inflight.
REQ-016 Response cycle (inflight=1, redirect=0, stall=0): on the next edge the block SHALL set ins=imem_rdata, ins_pc=inflight_pc, ins_valid=1.
REQ-017 Response cycle with stall=1 and redirect=0: the block SHALL capture imem_rdata/inflight_pc into the skid with skid_valid=1 and leave the outputs unchanged.
REQ-018 Non-response cycle with stall=0 and skid_valid=1: the block SHALL load the outputs from the skid (ins_valid=1) and clear skid_valid.
REQ-019 Non-response cycle with stall=0 and skid_valid=0: the block SHALL clear ins_valid and hold ins/ins_pc.
REQ-020 With stall=1 and redirect=0, the block SHALL keep ins, ins_pc and ins_valid unchanged and SHALL NOT change pc.
REQ-021 redirect=1 SHALL override stall: the block SHALL set pc=redirect_pc, drop any response arriving that cycle, clear skid_valid and ins_valid, and issue no request that cycle.
REQ-022 At most one request SHALL be outstanding, and a response and a valid skid SHALL never coexist.
REQ-023 Fetch-to-output latency SHALL be 2 edges with no stall: request at edge N, ins_valid=1 after edge N+1.

Reset
REQ-024 While rst_n=0, the block SHALL asynchronously force pc=RESET_PC, inflight=0, skid_valid=0, ins=0, ins_pc=0, ins_valid=0 and imem_req=0.
REQ-025 Reset asserted mid-operation SHALL discard any outstanding response, and fetch SHALL restart at RESET_PC after release.

Configuration
REQ-026 With IF_SQUASH_CNT_EN defined, output squash_cnt (16 bits, reset 0) SHALL increment on every response dropped by redirect and saturate at 16'hFFFF.
REQ-027 Without IF_SQUASH_CNT_EN, the squash_cnt port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-028 Reset release with stall=0 and memory returning addr^32'hA5A5_0000 -> ins_pc sequence 0,4,8 with ins_valid=1 from the 2nd edge, each ins matching its address.
REQ-029 Assert stall for 3 cycles at the response cycle of pc=8 -> ins/ins_pc hold the previous word and the pc=8 word sits in the skid; on release, ins_pc=8 and then 12, with no loss or duplication.
REQ-030 redirect=1 with redirect_pc=32'h100 while pc=0x10 is in flight -> the 0x10 word is dropped, ins_valid=0, and the next delivered ins_pc=0x100 (squash_cnt=1 if enabled).
REQ-031 redirect during stall with the skid full -> skid cleared, outputs invalid, and fetch resumes at redirect_pc.
REQ-032 redirect_pc=32'hFFFF_FFFC -> delivered ins_pc sequence FFFF_FFFC then 0.
REQ-033 Assert rst_n=0 mid-stream with an outstanding request -> outputs are 0 immediately, and the first ins_pc after release equals RESET_PC.
